// File: rtl/axi_lite_read_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-Lite read master port.
// One transaction in flight; the winner owns the downstream port from AR handshake to R handshake.
module axi_lite_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,

    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [RESP_WIDTH-1:0] s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,

    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [RESP_WIDTH-1:0] s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [RESP_WIDTH-1:0] m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;

    logic                  w_req_any;
    logic                  w_win;
    logic                  w_accept;
    logic                  w_sel_rready;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        w_req_any = s0_axi_arvalid | s1_axi_arvalid;
        if (s0_axi_arvalid && s1_axi_arvalid) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = s1_axi_arvalid;
        end
        w_accept     = (r_state == ST_IDLE) && w_req_any;
        w_sel_rready = r_grant ? s1_axi_rready : s0_axi_rready;
    end

    always_comb begin
        w_state_nxt    = r_state;
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        s0_axi_rvalid  = 1'b0;
        s0_axi_rdata   = '0;
        s0_axi_rresp   = '0;
        s1_axi_rvalid  = 1'b0;
        s1_axi_rdata   = '0;
        s1_axi_rresp   = '0;
        m_axi_rready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    s0_axi_arready = ~w_win;
                    s1_axi_arready = w_win;
                    w_state_nxt    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready = w_sel_rready;
                if (r_grant) begin
                    s1_axi_rvalid = m_axi_rvalid;
                    s1_axi_rdata  = m_axi_rdata;
                    s1_axi_rresp  = m_axi_rresp;
                end else begin
                    s0_axi_rvalid = m_axi_rvalid;
                    s0_axi_rdata  = m_axi_rdata;
                    s0_axi_rresp  = m_axi_rresp;
                end
                if (m_axi_rvalid && w_sel_rready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so s0 wins the first simultaneous request.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_araddr     <= w_win ? s1_axi_araddr : s0_axi_araddr;
                r_arvalid    <= 1'b1;
                r_grant      <= w_win;
                r_last_grant <= w_win;
            end else if ((r_state == ST_ADDR) && m_axi_arready) begin
                r_arvalid <= 1'b0;
            end
        end
    end

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign grant         = r_grant;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Randomized bench for axi_lite_read_arbiter: a transaction-level model predicts winners,
// bus phases and returned data; a negedge monitor compares and keeps the scoreboard.
module tb_axi_lite_read_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RW = 3;

    logic          clk;
    logic          axi_aresetn;
    logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
    logic          s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready;
    logic          s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready;
    logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
    logic [RW-1:0] s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
    logic          m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic          grant, busy;

    axi_lite_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
        .axi_aclk(clk), .axi_aresetn(axi_aresetn),
        .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rvalid(s0_axi_rvalid),
        .s0_axi_rready(s0_axi_rready),
        .s1_axi_araddr(s1_axi_araddr), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rvalid(s1_axi_rvalid),
        .s1_axi_rready(s1_axi_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Downstream memory contents as a pure function of address.
    function automatic logic [DW-1:0] f_data(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'hA5, 8'h3C};
    endfunction

    function automatic logic [RW-1:0] f_resp(input logic [AW-1:0] a);
        return (a[4:2] == 3'd7) ? 3'd2 : {1'b0, a[1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state, owned by the monitor.
    logic          md_last, md_grant, md_busy, md_apend;
    logic [34:0]   exp_q0[$];
    logic [34:0]   exp_q1[$];
    logic [AW-1:0] maddr_q[$];
    int            done_cnt = 0;

    // Handshakes seen at the latest negedge, consumed by the driver after the next posedge.
    logic          ar_hs0, ar_hs1, mar_hs, mr_hs;
    logic [AW-1:0] mar_addr;

    always @(negedge clk) begin : monitor
        logic          dph, win, sel_rready;
        logic [AW-1:0] a;
        logic [34:0]   e;
        if (!axi_aresetn) begin
            check("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
            check("rst_m_araddr", 64'(m_axi_araddr), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_grant", 64'(grant), 64'd0);
            check("rst_rvalid", 64'({s1_axi_rvalid, s0_axi_rvalid}), 64'd0);
            check("rst_arready", 64'({s1_axi_arready, s0_axi_arready}), 64'd0);
            md_last = 1'b1; md_grant = 1'b0; md_busy = 1'b0; md_apend = 1'b0;
            exp_q0.delete(); exp_q1.delete(); maddr_q.delete();
            ar_hs0 = 1'b0; ar_hs1 = 1'b0; mar_hs = 1'b0; mr_hs = 1'b0; mar_addr = '0;
        end else begin
            dph        = md_busy && !md_apend;
            sel_rready = md_grant ? s1_axi_rready : s0_axi_rready;
            ar_hs0     = s0_axi_arvalid && s0_axi_arready;
            ar_hs1     = s1_axi_arvalid && s1_axi_arready;
            mar_hs     = m_axi_arvalid && m_axi_arready;
            mar_addr   = m_axi_araddr;
            mr_hs      = m_axi_rvalid && m_axi_rready;

            check("busy", 64'(busy), 64'(md_busy));
            check("grant", 64'(grant), 64'(md_grant));
            check("m_arvalid", 64'(m_axi_arvalid), 64'(md_apend));
            check("m_rready", 64'(m_axi_rready), 64'(dph ? sel_rready : 1'b0));
            check("s0_rvalid", 64'(s0_axi_rvalid), 64'((dph && !md_grant) ? m_axi_rvalid : 1'b0));
            check("s1_rvalid", 64'(s1_axi_rvalid), 64'((dph && md_grant) ? m_axi_rvalid : 1'b0));
            if (dph && md_grant)
                check("s0_idle_data", 64'({s0_axi_rresp, s0_axi_rdata}), 64'd0);
            if (dph && !md_grant)
                check("s1_idle_data", 64'({s1_axi_rresp, s1_axi_rdata}), 64'd0);
            if (md_apend && maddr_q.size() > 0)
                check("m_araddr", 64'(m_axi_araddr), 64'(maddr_q[0]));

            if (!md_busy) begin
                if (s0_axi_arvalid || s1_axi_arvalid) begin
                    win = (s0_axi_arvalid && s1_axi_arvalid) ? !md_last : s1_axi_arvalid;
                    check("arb_winner", 64'({s1_axi_arready, s0_axi_arready}), win ? 64'd2 : 64'd1);
                    a = win ? s1_axi_araddr : s0_axi_araddr;
                    if (win) exp_q1.push_back({f_data(a), f_resp(a)});
                    else     exp_q0.push_back({f_data(a), f_resp(a)});
                    maddr_q.push_back(a);
                    md_busy = 1'b1; md_apend = 1'b1; md_grant = win; md_last = win;
                end else begin
                    check("arready_idle", 64'({s1_axi_arready, s0_axi_arready}), 64'd0);
                end
            end else begin
                check("arready_busy", 64'({s1_axi_arready, s0_axi_arready}), 64'd0);
                if (md_apend) begin
                    if (m_axi_arready) begin
                        md_apend = 1'b0;
                        if (maddr_q.size() > 0) void'(maddr_q.pop_front());
                    end
                end else if (m_axi_rvalid && sel_rready) begin
                    if (md_grant ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
                        check("exp_queue_empty", 64'd1, 64'd0);
                    end else if (md_grant) begin
                        e = exp_q1.pop_front();
                        check("s1_rdata", 64'(s1_axi_rdata), 64'(e[34:3]));
                        check("s1_rresp", 64'(s1_axi_rresp), 64'(e[2:0]));
                    end else begin
                        e = exp_q0.pop_front();
                        check("s0_rdata", 64'(s0_axi_rdata), 64'(e[34:3]));
                        check("s0_rresp", 64'(s0_axi_rresp), 64'(e[2:0]));
                    end
                    md_busy = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    // Driver state: requester intent and the downstream responder.
    logic          req0, req1, rsp_pend, hold_ar;
    logic [AW-1:0] addr0, addr1, rsp_addr;
    int            rsp_dly;

    // mode: 0 no new requests, 1 both always request, 2 random, 3 s1 always requests
    task automatic step(input int mode);
        logic [31:0] rnd;
        @(posedge clk); #1;
        if (ar_hs0) req0 = 1'b0;
        if (ar_hs1) req1 = 1'b0;
        rnd = $urandom;
        case (mode)
            1: begin
                if (!req0) begin req0 = 1'b1; addr0 = rnd[7:0]; end
                if (!req1) begin req1 = 1'b1; addr1 = rnd[15:8]; end
            end
            2: begin
                if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; addr0 = rnd[7:0]; end
                else if (req0 && $urandom_range(0, 15) == 0) req0 = 1'b0;
                if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; addr1 = rnd[15:8]; end
                else if (req1 && $urandom_range(0, 15) == 0) req1 = 1'b0;
            end
            3: if (!req1) begin req1 = 1'b1; addr1 = rnd[15:8]; end
            default: ;
        endcase
        rnd = $urandom;
        s0_axi_arvalid = req0;
        s0_axi_araddr  = req0 ? addr0 : rnd[7:0];
        s1_axi_arvalid = req1;
        s1_axi_araddr  = req1 ? addr1 : rnd[15:8];
        s0_axi_rready  = ($urandom_range(0, 3) != 0);
        s1_axi_rready  = ($urandom_range(0, 3) != 0);
        if (mr_hs) rsp_pend = 1'b0;
        if (mar_hs) begin
            rsp_pend = 1'b1; rsp_addr = mar_addr; rsp_dly = int'($urandom_range(0, 3));
        end
        rnd = $urandom;
        if (rsp_pend) begin
            if (rsp_dly > 0) begin
                rsp_dly--; m_axi_rvalid = 1'b0;
            end else begin
                m_axi_rvalid = 1'b1; m_axi_rdata = f_data(rsp_addr); m_axi_rresp = f_resp(rsp_addr);
            end
        end else begin
            m_axi_rvalid = ($urandom_range(0, 7) == 0);
            m_axi_rdata  = rnd;
            m_axi_rresp  = rnd[2:0];
        end
        m_axi_arready = hold_ar ? 1'b0 : ($urandom_range(0, 1) == 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((req0 || req1 || md_busy || rsp_pend) && n < 300) begin
            step(0);
            n++;
        end
        check("drain_timeout", 64'(req0 || req1 || md_busy || rsp_pend), 64'd0);
    endtask

    task automatic run_until(input int mode, input int target, input int limit, input string name);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            step(mode);
            n++;
        end
        check(name, 64'(done_cnt >= target), 64'd1);
    endtask

    initial begin
        int base;
        int n;
        axi_aresetn = 1'b0;
        s0_axi_araddr = '0; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
        s1_axi_araddr = '0; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rsp_pend = 1'b0; hold_ar = 1'b0;
        addr0 = '0; addr1 = '0; rsp_addr = '0; rsp_dly = 0;
        repeat (3) @(posedge clk);
        #1 axi_aresetn = 1'b1;

        // Simultaneous first requests: s0 must go first, then s1 (0x1C returns an error resp).
        req0 = 1'b1; addr0 = 8'h0C; req1 = 1'b1; addr1 = 8'h1C;
        s0_axi_arvalid = 1'b1; s0_axi_araddr = addr0;
        s1_axi_arvalid = 1'b1; s1_axi_araddr = addr1;
        run_until(0, 2, 80, "first_pair_done");
        drain();

        base = done_cnt;
        run_until(1, base + 6, 200, "contention_done");
        drain();

        repeat (1500) step(2);
        drain();

        // Reset while s1's address sits unaccepted downstream.
        hold_ar = 1'b1;
        n = 0;
        while (!m_axi_arvalid && n < 30) begin
            step(3);
            n++;
        end
        check("reach_addr_phase", 64'(m_axi_arvalid && grant), 64'd1);
        #2 axi_aresetn = 1'b0;
        #1;
        check("async_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_grant", 64'(grant), 64'd0);
        req0 = 1'b0; req1 = 1'b0; rsp_pend = 1'b0; hold_ar = 1'b0;
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0;
        @(posedge clk); #1;
        axi_aresetn = 1'b1;
        base = done_cnt;
        req1 = 1'b1; addr1 = 8'h1C;
        s1_axi_arvalid = 1'b1; s1_axi_araddr = addr1;
        run_until(0, base + 1, 60, "post_reset_done");
        drain();

        check("queues_empty", 64'(exp_q0.size() + exp_q1.size() + maddr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
